bcd_serial_add_ctrl: RTL and testbench

//  Sequencer that owns a single-digit BCD adder and drives it one digit per clock.
//  It adds two NDIGITS-wide packed BCD operands, least significant digit first,

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_serial_add_ctrl_if.sv | 30 +++
 rtl/bcd_digit_add.sv | 30 +++
 rtl/bcd_serial_add_ctrl.sv | 152 +++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared BCD types, digit limit, sequencer states, digit check.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ADD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_add_ctrl_if
// Description : Start/busy/done handshake plus operand and result buses.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_serial_add_ctrl_if #(
    parameter int NDIGITS = 4
);
    logic                   start;
    logic [4*NDIGITS-1:0]   a_bcd;
    logic [4*NDIGITS-1:0]   b_bcd;
    logic                   cin;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   sum_bcd;
    logic                   cout;
    logic                   err;

    modport master (
        output start, a_bcd, b_bcd, cin,
        input  busy, done, sum_bcd, cout, err
    );

    modport slave (
        input  start, a_bcd, b_bcd, cin,
        output busy, done, sum_bcd, cout, err
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_add.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_add
// Description : Combinational single-digit decimal adder with carry in/out.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       ci,
    output bcd_digit_t s,
    output logic       co
);
    // Five bits hold the worst case 9 + 9 + 1 = 19.
    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        if (raw > {1'b0, BCD_MAX}) begin
            s  = raw[3:0] + 4'd6;
            co = 1'b1;
        end else begin
            s  = raw[3:0];
            co = 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_add_ctrl
// Description : Digit-serial BCD adder sequencer, LSD first, with operand check.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int             W        = 4 * NDIGITS;
    localparam int             IW       = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(NDIGITS - 1);

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic            cin_q;
    logic            carry_q;
    logic            cout_q;
    logic            err_q;
    logic [IW-1:0]   idx;

    logic            accept;
    logic            busy_c;
    logic            done_c;
    logic            operands_ok;
    logic [IW+1:0]   bit_base;
    bcd_digit_t      dig_a;
    bcd_digit_t      dig_b;
    bcd_digit_t      dig_s;
    logic            dig_co;

    always_comb begin
        operands_ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!is_bcd(a_q[4*i +: 4]) || !is_bcd(b_q[4*i +: 4])) begin
                operands_ok = 1'b0;
            end
        end
    end

    assign bit_base = {idx, 2'b00};
    assign dig_a    = a_q[bit_base +: 4];
    assign dig_b    = b_q[bit_base +: 4];

    bcd_digit_add u_digit_add (
        .a  (dig_a),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                busy_c     = 1'b1;
                state_next = operands_ok ? ADD : DONE;
            end
            ADD: begin
                busy_c = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // A start here is taken without an idle bubble.
                done_c = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = CHECK;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_q    <= bus.a_bcd;
            b_q    <= bus.b_bcd;
            cin_q  <= bus.cin;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (!operands_ok) begin
                        err_q <= 1'b1;
                    end else begin
                        idx     <= '0;
                        carry_q <= cin_q;
                    end
                end
                ADD: begin
                    sum_q[bit_base +: 4] <= dig_s;
                    carry_q              <= dig_co;
                    idx                  <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_q <= dig_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy_c;
    assign bus.done    = done_c;
    assign bus.sum_bcd = sum_q;
    assign bus.cout    = cout_q;
    assign bus.err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_add_ctrl
// Description : Scoreboard bench with a decimal-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_add_ctrl;
    localparam int N = 4;

    typedef struct {
        logic [4*N-1:0] sum;
        logic           cout;
        logic           err;
        int             lat;
        int             bsy;
        int             acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   busy_cnt;
    exp_t exp_q[$];
    int   done_cycs[$];

    bcd_serial_add_ctrl_if #(.NDIGITS(N)) bus ();

    bcd_serial_add_ctrl #(.NDIGITS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Decimal reference: digits -> integers, add, split back into digits.
    function automatic exp_t model(input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                                   input logic c);
        exp_t e;
        int   ai  = 0;
        int   bi  = 0;
        int   lim = 1;
        int   s;
        bit   bad_dig = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_dig = 1;
            ai = ai * 10 + int'(a[4*i +: 4]);
            bi = bi * 10 + int'(b[4*i +: 4]);
            lim = lim * 10;
        end
        e.sum = '0;
        e.acc = 0;
        if (bad_dig) begin
            e.cout = 1'b0;
            e.err  = 1'b1;
            e.lat  = 1;
            e.bsy  = 1;
        end else begin
            s      = ai + bi + int'(c);
            e.cout = (s >= lim);
            s      = s % lim;
            for (int i = 0; i < N; i++) begin
                e.sum[4*i +: 4] = 4'(s % 10);
                s = s / 10;
            end
            e.err = 1'b0;
            e.lat = N + 1;
            e.bsy = N + 1;
        end
        return e;
    endfunction

    function automatic logic [4*N-1:0] rand_operand(input bit allow_bad);
        logic [4*N-1:0] v;
        for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        if (allow_bad && ($urandom_range(0, 4) == 0))
            v[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
        return v;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cycs.push_back(cyc);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done got=1 want=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum_bcd", bus.sum_bcd, e.sum);
                    chk("cout", bus.cout, e.cout);
                    chk("err", bus.err, e.err);
                    chk("latency", cyc - e.acc, e.lat);
                    chk("busy_cycles", busy_cnt, e.bsy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL ready_timeout busy got=1 want=0");
        end
    endtask

    // Called at a negedge with busy low; start is taken at the next posedge.
    task automatic issue(input logic [4*N-1:0] a, input logic [4*N-1:0] b,
                         input logic c, input bit hold);
        exp_t e;
        e     = model(a, b, c);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.cin   = c;
        bus.start = 1'b1;
        @(negedge clk);
        chk("cleared_sum", bus.sum_bcd, 0);
        chk("busy_after_start", bus.busy, 1);
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending got=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        busy_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a_bcd = '0;
        bus.b_bcd = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sum", bus.sum_bcd, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_err", bus.err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        issue(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_ready();
        issue(16'h9999, 16'h0001, 1'b0, 1'b0);
        wait_ready();
        issue(16'h9999, 16'h9999, 1'b1, 1'b0);
        wait_ready();
        issue(16'h12A4, 16'h0000, 1'b0, 1'b0);
        wait_ready();
        issue(16'h0000, 16'h0000, 1'b1, 1'b0);
        drain();

        // Start held high, operands scrambled while busy, back-to-back accept.
        done_cycs.delete();
        wait_ready();
        issue(16'h4567, 16'h2345, 1'b1, 1'b1);
        begin
            int n = 0;
            while (bus.busy && n < 50) begin
                bus.a_bcd = 16'($urandom);
                bus.b_bcd = 16'($urandom);
                bus.cin   = 1'($urandom);
                @(negedge clk);
                n++;
            end
        end
        issue(16'h0808, 16'h0303, 1'b0, 1'b0);
        drain();
        if (done_cycs.size() >= 2) begin
            chk("done_spacing", done_cycs[done_cycs.size()-1] - done_cycs[done_cycs.size()-2], N + 2);
        end else begin
            total++;
            bad++;
            $display("FAIL done_spacing got=%0d pulses want=2", done_cycs.size());
        end

        // Reset during the second ADD cycle.
        wait_ready();
        issue(16'h1234, 16'h5678, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_sum", bus.sum_bcd, 0);
        chk("abort_cout", bus.cout, 0);
        chk("abort_err", bus.err, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0456, 16'h0789, 1'b1, 1'b0);
        drain();

        // Random operands, occasional bad digit and idle gaps.
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            wait_ready();
            issue(rand_operand(1'b1), rand_operand(1'b1), 1'($urandom), 1'b0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
